// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared state codes and op-class enum for the ARM decoder front end
package arm_pkg;

    localparam logic [6:0] ST_RESET   = 7'd0;
    localparam logic [6:0] ST_UNSUPP  = 7'd127;
    localparam logic [6:0] ST_DP_BASE  = 7'd16;
    localparam logic [6:0] ST_LSI_BASE = 7'd32;
    localparam logic [6:0] ST_LSR_BASE = 7'd64;
    localparam logic [6:0] ST_BR_BASE  = 7'd96;

    typedef enum logic [2:0] {
        OP_DP_REG = 3'b000,
        OP_DP_IMM = 3'b001,
        OP_LS_IMM = 3'b010,
        OP_LS_REG = 3'b011,
        OP_LDM    = 3'b100,
        OP_BRANCH = 3'b101,
        OP_COPROC = 3'b110,
        OP_SWI    = 3'b111
    } op_class_e;

    function automatic op_class_e op_class(input logic [31:0] instr);
        return op_class_e'(instr[27:25]);
    endfunction

endpackage

// File: rtl/arm_encode_comb.sv
// rtl/arm_encode_comb.sv - combinational instruction word to microstore state code
module arm_encode_comb
    import arm_pkg::*;
(
    input  logic [31:0] I,
    output logic [6:0]  code_o
);

    logic       s_bit;
    logic       tst;
    logic [1:0] fm;
    logic       dp_ok;

    assign s_bit = I[20];
    assign tst   = (I[24:23] == 2'b10);

    always_comb begin
        fm    = 2'b00;
        dp_ok = 1'b1;
        if (I[25]) begin
            fm = 2'b00;
        end else if (!I[4]) begin
            fm = 2'b01;
        end else if (!I[7]) begin
            fm = 2'b10;
        end else begin
            // multiply and extra load/store encodings share this space
            dp_ok = 1'b0;
        end
        // compare-class opcode without S is the status-register transfer space
        if (tst && !s_bit) begin
            dp_ok = 1'b0;
        end
    end

    always_comb begin
        code_o = ST_UNSUPP;
        unique case (op_class(I))
            OP_DP_REG, OP_DP_IMM: begin
                if (dp_ok) begin
                    code_o = ST_DP_BASE | {3'b000, fm, s_bit, tst};
                end
            end
            OP_LS_IMM: code_o = ST_LSI_BASE | {2'b00, I[24:20]};
            OP_LS_REG: begin
                if (!I[4]) begin
                    code_o = ST_LSR_BASE | {2'b00, I[24:20]};
                end
            end
            OP_BRANCH: code_o = ST_BR_BASE | {6'b000000, I[24]};
            default:   code_o = ST_UNSUPP;
        endcase
    end

endmodule

// File: rtl/arm_encoder.sv
// rtl/arm_encoder.sv - registered microstore state code with capture enable
module arm_encoder
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] I,
    output logic [6:0]  encOut
);

    logic [6:0] code;
    logic [6:0] enc_q, enc_d;
    logic       armed_q, armed_d;

    arm_encode_comb u_comb (
        .I      (I),
        .code_o (code)
    );

    // The edge on which reset releases only arms the register, so a capture
    // never races the reset deassertion.
    always_comb begin
        armed_d = 1'b1;
        enc_d   = enc_q;
        if (armed_q && en) begin
            enc_d = code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            enc_q   <= ST_RESET;
        end else begin
            armed_q <= armed_d;
            enc_q   <= enc_d;
        end
    end

    assign encOut = enc_q;

endmodule

// File: tb/tb_arm_encoder.sv
// tb/tb_arm_encoder.sv - directed self-checking bench for arm_encoder
module tb_arm_encoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] I;
    logic [6:0]  encOut;

    int n_cmp;
    int n_err;

    arm_encoder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .I      (I),
        .encOut (encOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        if (encOut !== 7'd0) begin
            $display("FAIL reset_initial: got %b want %b", encOut, 7'd0);
            n_err++;
        end
        n_cmp++;
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        step();
        en = 1'b1;
        I  = 32'hE201_0000;
        step();
        if (encOut !== 7'd16) begin
            $display("FAIL and_imm_first: got %b want %b", encOut, 7'd16);
            n_err++;
        end
        n_cmp++;
        // asynchronous reset mid-cycle with capture enabled
        I = 32'hEA00_0001;
        #2 rst_n = 1'b0;
        #1;
        if (encOut !== 7'd0) begin
            $display("FAIL reset_async: got %b want %b", encOut, 7'd0);
            n_err++;
        end
        n_cmp++;
        step();
        step();
        if (encOut !== 7'd0) begin
            $display("FAIL reset_held: got %b want %b", encOut, 7'd0);
            n_err++;
        end
        n_cmp++;
        rst_n = 1'b1;
        en    = 1'b0;
        step();
        en = 1'b1;
        I  = 32'hE201_0000;
        step();
        if (encOut !== 7'd16) begin
            $display("FAIL and_imm_after_release: got %b want %b", encOut, 7'd16);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_data_proc();
        logic [31:0] vec [8];
        logic [6:0]  exp [8];
        vec[0] = 32'hE380_1028; exp[0] = 7'b0010000;
        vec[1] = 32'hE253_3001; exp[1] = 7'b0010010;
        vec[2] = 32'hE080_5000; exp[2] = 7'b0010100;
        vec[3] = 32'hE082_5005; exp[3] = 7'b0010100;
        vec[4] = 32'hE150_0001; exp[4] = 7'b0010111;
        vec[5] = 32'hE081_0312; exp[5] = 7'b0011000;
        vec[6] = 32'hE151_0312; exp[6] = 7'b0011011;
        vec[7] = 32'hE100_0000; exp[7] = 7'b1111111;
        for (int k = 0; k < 8; k++) begin
            I = vec[k];
            step();
            if (encOut !== exp[k]) begin
                $display("FAIL dp_%0d I=%h: got %b want %b", k, vec[k], encOut, exp[k]);
                n_err++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_load_store();
        logic [31:0] vec [3];
        logic [6:0]  exp [3];
        vec[0] = 32'hE5D1_3002; exp[0] = 7'b0111101;
        vec[1] = 32'hE5C1_5003; exp[1] = 7'b0111100;
        vec[2] = 32'hE7D1_2000; exp[2] = 7'b1011101;
        for (int k = 0; k < 3; k++) begin
            I = vec[k];
            step();
            if (encOut !== exp[k]) begin
                $display("FAIL ls_%0d I=%h: got %b want %b", k, vec[k], encOut, exp[k]);
                n_err++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_branch();
        logic [31:0] vec [4];
        logic [6:0]  exp [4];
        vec[0] = 32'h1AFF_FFFD; exp[0] = 7'b1100000;
        vec[1] = 32'hEA00_0001; exp[1] = 7'b1100000;
        vec[2] = 32'hEAFF_FFFF; exp[2] = 7'b1100000;
        vec[3] = 32'h0B05_0704; exp[3] = 7'b1100001;
        for (int k = 0; k < 4; k++) begin
            I = vec[k];
            step();
            if (encOut !== exp[k]) begin
                $display("FAIL br_%0d I=%h: got %b want %b", k, vec[k], encOut, exp[k]);
                n_err++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_unsupported();
        logic [31:0] vec [4];
        vec[0] = 32'hE000_0090;
        vec[1] = 32'hE700_0010;
        vec[2] = 32'hE8BD_0000;
        vec[3] = 32'hEF00_0000;
        for (int k = 0; k < 4; k++) begin
            I = 32'hE201_0000;
            step();
            I = vec[k];
            step();
            if (encOut !== 7'b1111111) begin
                $display("FAIL unsupp_%0d I=%h: got %b want %b", k, vec[k], encOut, 7'b1111111);
                n_err++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_hold();
        logic [31:0] vec [3];
        vec[0] = 32'hEA00_0001;
        vec[1] = 32'hE5D1_3002;
        vec[2] = 32'hEF00_0000;
        I = 32'hE253_3001;
        step();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            I = vec[k];
            step();
            if (encOut !== 7'b0010010) begin
                $display("FAIL hold_%0d: got %b want %b", k, encOut, 7'b0010010);
                n_err++;
            end
            n_cmp++;
        end
        en = 1'b1;
        I  = 32'h0B05_0704;
        #1;
        if (encOut !== 7'b0010010) begin
            $display("FAIL hold_before_edge: got %b want %b", encOut, 7'b0010010);
            n_err++;
        end
        n_cmp++;
        step();
        if (encOut !== 7'b1100001) begin
            $display("FAIL hold_release: got %b want %b", encOut, 7'b1100001);
            n_err++;
        end
        n_cmp++;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        I     = 32'h0;
        #1;
        test_reset();
        test_data_proc();
        test_load_store();
        test_branch();
        test_unsupported();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
